bcd_sub_serial: RTL and testbench

BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_digit_sub.sv | 37 +++
 rtl/bcd_sub_serial.sv | 179 +++++++++++++++++
 tb/tb_bcd_sub_serial.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   BCD_RADIX  : decimal radix, added back to a digit after a borrow
//   BCD_MAX    : largest legal BCD digit value
//   digit_bad(): 1 when a 4-bit code is not a legal BCD digit (10..15)
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_RADIX = 10;
    localparam int BCD_MAX   = 9;

    function automatic logic digit_bad(input logic [3:0] dig);
        return dig > 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Purely combinational single-digit BCD subtractor: d = a_d - b_d - bin,
// folded back into 0..9 by adding the radix when the raw result is negative.
// Ports:
//   a_d [3:0] : minuend digit (0..9 for a meaningful result)
//   b_d [3:0] : subtrahend digit
//   bin       : borrow in from the less significant digit
//   d   [3:0] : result digit
//   bo        : borrow out (raw difference was negative)
// -----------------------------------------------------------------------------
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bo
);

    // Five bits hold every raw result from +15 down to -16, so bit 4 is the
    // sign of the raw difference. Adding the radix to the low nibble modulo
    // 16 gives (raw + 10) for any raw in -10..-1.
    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a_d} - {1'b0, b_d} - {4'd0, bin};
        bo  = raw[4];
        if (raw[4]) begin
            d = raw[3:0] + 4'(BCD_RADIX);
        end else begin
            d = raw[3:0];
        end
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// -----------------------------------------------------------------------------
// bcd_sub_serial
// Digit-serial packed-BCD subtractor. One digit is processed per clock,
// least significant first, through a single shared bcd_digit_sub.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : launch request
//   a, b       : minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy       : high while digits are being processed (RUN)
//   done       : one-cycle completion pulse (DONE)
//   diff       : registered BCD result, (A - B) mod 10^NDIG
//   bout       : final borrow, 1 when A < B (diff is the ten's complement)
//   err        : an operand digit was 10..15; diff and bout forced to 0
//   state_dbg  : current controller state for observation
//
// Handshake: start is a request qualified by the controller being free; it is
// accepted on any rising edge where the state is IDLE or DONE (busy low), and
// a, b are captured on that same edge. While busy is high start is ignored and
// a, b may change freely. done pulses for exactly one cycle with busy low, and
// diff/bout/err are valid from that cycle until the next completion. A start
// seen during the done cycle launches the next operation with no gap.
// -----------------------------------------------------------------------------
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] diff,
    output logic              bout,
    output logic              err,
    output state_t            state_dbg
);

    localparam int             IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NDIG - 1);

    state_t            state;
    state_t            state_nx;

    logic [4*NDIG-1:0] a_q;
    logic [4*NDIG-1:0] b_q;
    logic [4*NDIG-1:0] acc;
    logic [4*NDIG-1:0] acc_nx;
    logic [IW-1:0]     idx;
    logic              borrow;
    logic              err_lat;

    logic              launch;
    logic              last;
    logic              in_bad;
    logic [3:0]        dig_a;
    logic [3:0]        dig_b;
    logic [3:0]        dig_d;
    logic              dig_bo;

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        last     = (idx == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    launch   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    launch   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Operand validity, judged on the raw inputs at the launch edge so the
    // flag travels with the latched operands.
    // -------------------------------------------------------------------------
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_bad(a[i*4 +: 4]) || digit_bad(b[i*4 +: 4])) begin
                in_bad = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Shared digit datapath
    // -------------------------------------------------------------------------
    always_comb begin
        dig_a = a_q[idx*4 +: 4];
        dig_b = b_q[idx*4 +: 4];
    end

    bcd_digit_sub u_digit (
        .a_d (dig_a),
        .b_d (dig_b),
        .bin (borrow),
        .d   (dig_d),
        .bo  (dig_bo)
    );

    // Partial result with the current digit merged in; on the last digit this
    // is the complete difference and goes straight to the output register.
    always_comb begin
        acc_nx               = acc;
        acc_nx[idx*4 +: 4]   = dig_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
            err_lat <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            err     <= 1'b0;
        end else if (launch) begin
            a_q     <= a;
            b_q     <= b;
            acc     <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
            err_lat <= in_bad;
        end else if (state == RUN) begin
            acc    <= acc_nx;
            borrow <= dig_bo;
            if (last) begin
                idx  <= '0;
                // Result registers only change on the way into DONE.
                diff <= err_lat ? '0 : acc_nx;
                bout <= err_lat ? 1'b0 : dig_bo;
                err  <= err_lat;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_bcd_sub_serial
// Self-checking bench for bcd_sub_serial (NDIG = 4): directed cases followed
// by random operands compared against a decimal-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bcd_sub_serial;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic             busy;
    logic             done;
    logic [W-1:0]     diff;
    logic             bout;
    logic             err;
    bcd_pkg::state_t  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_sub_serial #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: plain decimal arithmetic on the operand values.
    // -------------------------------------------------------------------------
    function automatic void model(input logic [W-1:0] av_bcd, input logic [W-1:0] bv_bcd,
                                  output logic [W-1:0] d, output logic bo, output logic er);
        int av;
        int bv;
        int dv;
        int modv;
        logic [3:0] da;
        logic [3:0] db;
        av   = 0;
        bv   = 0;
        modv = 1;
        er   = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            da = av_bcd[i*4 +: 4];
            db = bv_bcd[i*4 +: 4];
            if (da > 4'd9 || db > 4'd9) er = 1'b1;
            av   = av * 10 + int'(da);
            bv   = bv * 10 + int'(db);
            modv = modv * 10;
        end
        d  = '0;
        bo = 1'b0;
        if (!er) begin
            bo = (av < bv);
            dv = av - bv;
            if (dv < 0) dv = dv + modv;
            for (int i = 0; i < NDIG; i++) begin
                d[i*4 +: 4] = 4'(dv % 10);
                dv = dv / 10;
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // Comparison point
    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Driver: called at a falling edge; launches an operation and checks the
    // whole busy/done timeline plus the result.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_er);
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        for (int k = 1; k <= NDIG; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_low"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_low"}, 32'(busy), 32'd0);
        chk({tag, " diff"}, 32'(diff), 32'(exp_d));
        chk({tag, " bout"}, 32'(bout), 32'(exp_bo));
        chk({tag, " err"}, 32'(err), 32'(exp_er));
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rd;
    logic         rbo;
    logic         rer;
    logic         saw_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst diff", 32'(diff), 32'd0);
        chk("rst bout", 32'(bout), 32'd0);
        chk("rst err",  32'(err),  32'd0);
        rst_n = 1'b1;

        // Start accepted on the first edge after reset release
        run_op("basic",    16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0);
        run_op("zeros",    16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0);
        run_op("wrap",     16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
        run_op("equal",    16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0);
        run_op("baddigit", 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1);

        // Idle cycle, then start held high through RUN with changing operands
        start = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);
        a_in  = 16'h1234;
        b_in  = 16'h0567;
        start = 1'b1;
        for (int k = 1; k <= NDIG; k++) begin
            @(negedge clk);
            a_in = 16'h9999;
            b_in = 16'h0000;
            chk("hold busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("hold done", 32'(done), 32'd1);
        chk("hold diff", 32'(diff), 32'h0667);
        chk("hold err",  32'(err),  32'd0);
        a_in = 16'h0050;
        b_in = 16'h0025;
        // start still high in the DONE cycle: next op must begin immediately
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b done_low", 32'(done), 32'd0);
        for (int k = 2; k <= NDIG; k++) begin
            @(negedge clk);
            chk("b2b busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("b2b done", 32'(done), 32'd1);
        chk("b2b diff", 32'(diff), 32'h0025);
        chk("b2b bout", 32'(bout), 32'd0);

        // Reset during the second RUN cycle
        a_in  = 16'h4321;
        b_in  = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst diff", 32'(diff), 32'd0);
        chk("mid rst bout", 32'(bout), 32'd0);
        chk("mid rst err",  32'(err),  32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("mid rst no_done", 32'(saw_done), 32'd0);
        rst_n = 1'b1;
        run_op("after rst", 16'h4321, 16'h1111, 16'h3210, 1'b0, 1'b0);

        // Random operands, back to back
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NDIG; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                ra[$urandom_range(0, NDIG - 1)*4 +: 4] = 4'($urandom_range(10, 15));
            end
            model(ra, rb, rd, rbo, rer);
            run_op("rand", ra, rb, rd, rbo, rer);
        end

        start = 1'b0;
        @(negedge clk);
        chk("final idle", 32'(busy | done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
